net_event_tx: RTL

//  Event transmitter for the gate-level netlist simulator: snapshots a vector of
//  net values (outputs of mapped BUF/NAND/DFF/DFFSR cells) on request, compares

---
 rtl/net_event_tx.sv | 117 +++++++++++
 1 files changed

// File: rtl/net_event_tx.sv
// rtl/net_event_tx.sv - net-event transmitter: snapshot nets, send one (index, value) message per changed net
module net_event_tx #(
    parameter int NETS  = 16,
    parameter int IDX_W = 4
) (
    input  logic             C,
    input  logic             RN,
    input  logic [NETS-1:0]  NET,
    input  logic             SAMPLE,
    output logic             BUSY,
    output logic             EV_VALID,
    output logic [IDX_W-1:0] EV_IDX,
    output logic             EV_VAL,
    input  logic             EV_READY,
    output logic             DONE,
    output logic [IDX_W:0]   EV_CNT
);

    typedef enum logic [1:0] {IDLE, SCAN, SEND, FIN} state_t;

    state_t            state, state_n;
    logic [NETS-1:0]   snap, snap_n;
    logic [NETS-1:0]   sent, sent_n;
    logic [IDX_W-1:0]  ptr, ptr_n;
    logic [IDX_W:0]    cnt, cnt_n;
    logic              busy_n, valid_n, val_n, done_n;
    logic [IDX_W-1:0]  idx_n;
    logic [IDX_W:0]    ev_cnt_n;
    logic              last;

    assign last = (ptr == IDX_W'(NETS - 1));

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state    <= IDLE;
            snap     <= '0;
            sent     <= '0;
            ptr      <= '0;
            cnt      <= '0;
            BUSY     <= 1'b0;
            EV_VALID <= 1'b0;
            EV_IDX   <= '0;
            EV_VAL   <= 1'b0;
            DONE     <= 1'b0;
            EV_CNT   <= '0;
        end else begin
            state    <= state_n;
            snap     <= snap_n;
            sent     <= sent_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            BUSY     <= busy_n;
            EV_VALID <= valid_n;
            EV_IDX   <= idx_n;
            EV_VAL   <= val_n;
            DONE     <= done_n;
            EV_CNT   <= ev_cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        snap_n   = snap;
        sent_n   = sent;
        ptr_n    = ptr;
        cnt_n    = cnt;
        valid_n  = EV_VALID;
        idx_n    = EV_IDX;
        val_n    = EV_VAL;
        done_n   = 1'b0;
        ev_cnt_n = EV_CNT;
        case (state)
            IDLE: begin
                // BUSY is still high during the DONE cycle, which blocks a new scan there
                if (SAMPLE && !BUSY) begin
                    snap_n  = NET;
                    ptr_n   = '0;
                    cnt_n   = '0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (snap[ptr] != sent[ptr]) begin
                    idx_n   = ptr;
                    val_n   = snap[ptr];
                    valid_n = 1'b1;
                    state_n = SEND;
                end else if (last) begin
                    state_n = FIN;
                end else begin
                    ptr_n = ptr + 1'b1;
                end
            end
            SEND: begin
                if (EV_VALID && EV_READY) begin
                    sent_n[ptr] = snap[ptr];
                    cnt_n       = cnt + 1'b1;
                    valid_n     = 1'b0;
                    if (last) begin
                        state_n = FIN;
                    end else begin
                        ptr_n   = ptr + 1'b1;
                        state_n = SCAN;
                    end
                end
            end
            FIN: begin
                done_n   = 1'b1;
                ev_cnt_n = cnt;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE) || (state == FIN);
    end

endmodule
